thread_slice_ctl: RTL and testbench
===================================

# thread_slice_ctl

Time-slice controller sitting directly downstream of the threads manager. It requests the next runnable thread with `THREAD_CMD_GET_NEXT_STATE` and latches the thread start address and state pointer the manager returns. It then loads them into the CPU core, runs a fixed-length quantum, and has the core save context before asking for the next thread. This is the consumer of the manager's `next_proc`/state-pointer output and the producer of its get-next command.

## Interface

- `QUANTUM`, default 64: cycles per time slice; legal range 1..2^`CNT_W`-1.
- `CNT_W`, default 8: width of the slice counter.
- `WAIT_MAX`, default 15: cycles to wait for a selection before re-requesting.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `thrd_cmd`  out  4: `THREAD_CMD_GET_NEXT_STATE` for one cycle per request, otherwise 0.
- `sel_vld`  in  1: manager has placed a new selection on `next_proc`/`proc_state`.
- `next_proc`  in  `DATA_SIZE`: selected thread start address; 0 means no runnable thread.
- `proc_state`  in  `DATA_SIZE`: selected thread state pointer.
- `cpu_load`  out  1: one-cycle pulse; core loads `cpu_pc`/`cpu_state_ptr`.
- `cpu_pc`  out  `DATA_SIZE`: latched `next_proc`.
- `cpu_state_ptr`  out  `DATA_SIZE`: latched `proc_state`.
- `cpu_save`  out  1: held high until the core acknowledges the context save.
- `cpu_save_done`  in  1: core finished saving context.
- `cpu_yield`  in  1: running thread yields voluntarily (see Configuration).
- `stop_hit`  in  1: running thread was stopped; no save is needed.
- `running`  out  1: high in RUN.
- `slice_cnt`  out  `CNT_W`: remaining cycles in the current slice.
- `switch_cnt`  out  16: completed context loads; wraps 0xFFFF->0.

## Operation

- The FSM states are IDLE, REQ, WAIT, LOAD, RUN and SAVE. All outputs are registered.
- **Reset** (`rst`=0, asynchronous): state=IDLE. All outputs are 0: `thrd_cmd`, `cpu_load`, `cpu_save`, `cpu_pc`, `cpu_state_ptr`, `running`, `slice_cnt`, `switch_cnt`. The wait counter is also cleared.
- **IDLE**: go to REQ on the next edge, unconditionally.
- **REQ**: drive `thrd_cmd`=`THREAD_CMD_GET_NEXT_STATE` for exactly one cycle, clear the wait counter, then go to WAIT.
- **WAIT**, when `sel_vld`=1:
  - If `next_proc`≠0, latch `next_proc`→`cpu_pc` and `proc_state`→`cpu_state_ptr`, then go to LOAD.
  - If `next_proc`=0 (nothing runnable), go to IDLE. `cpu_pc` is not modified.
- **WAIT timeout**: with no `sel_vld`, the wait counter increments each cycle. When it reaches `WAIT_MAX`, go to REQ, which re-issues the command.
- **LOAD**:
  - `cpu_load`=1 for one cycle.
  - `slice_cnt`←`QUANTUM`.
  - `switch_cnt`←`switch_cnt`+1, modulo 2^16.
  - Go to RUN.
- **RUN**: `running`=1, and `slice_cnt` decrements by 1 each cycle. Exit priority:
  1. `stop_hit`=1: go to REQ directly, with no save.
  2. `cpu_yield`=1 (when enabled): go to SAVE.
  3. `slice_cnt`=1: this is the last cycle, so go to SAVE. `slice_cnt` reaches 0 on entry to SAVE.
- **SAVE**: `cpu_save`=1 held. When `cpu_save_done`=1, deassert `cpu_save` and go to REQ.
- **`stop_hit` during SAVE**: ignored. The save completes normally.
- **`sel_vld` outside WAIT**: ignored. No latch occurs.
- `cpu_pc` and `cpu_state_ptr` hold their values until the next accepted selection.

## Timing

- REQ→WAIT: 1 cycle. `thrd_cmd` is non-zero only in the cycle the FSM is in REQ.
- Minimum selection latency is 1 cycle: `sel_vld` in the first WAIT cycle gives LOAD on the next cycle.
- LOAD lasts 1 cycle. RUN lasts exactly `QUANTUM` cycles absent stop/yield.
- Slice-to-slice overhead: REQ(1) + WAIT(≥1) + LOAD(1) + SAVE(≥1) cycles.
- `cpu_save_done` in the first SAVE cycle gives REQ on the next cycle.
- **Reset mid-operation**: all outputs clear immediately (asynchronously), including a high `cpu_save`. Operation restarts from IDLE after `rst` deasserts.
- `slice_cnt` arithmetic is unsigned `CNT_W` bits and never underflows, because the exit is taken at 1.

## Configuration

- `THRD_SLICE_YIELD_EN` defined: `cpu_yield` in RUN ends the slice early and goes to SAVE, with priority below `stop_hit`.
- Not defined: `cpu_yield` is ignored. Slices end only on quantum expiry or `stop_hit`.

## Test plan

- **Reset release**: `rst` 0→1 -> IDLE, REQ and `thrd_cmd`=`THREAD_CMD_GET_NEXT_STATE` on exactly one cycle; all other outputs 0.
- **Full slice**: `sel_vld`=1 with `next_proc`=0x100 and `proc_state`=0x2000 -> one `cpu_load` pulse, `cpu_pc`=0x100, `cpu_state_ptr`=0x2000, `running` high for 64 cycles, then `cpu_save` high. `cpu_save_done` after 3 cycles -> new request; `switch_cnt`=1.
- **Empty / timeout**:
  - `sel_vld`=1 with `next_proc`=0 -> IDLE then REQ, with no `cpu_load`.
  - No `sel_vld` for 15 cycles -> a second `thrd_cmd` pulse.
- **Stop vs yield** (`THRD_SLICE_YIELD_EN` defined): `stop_hit` and `cpu_yield` together at slice cycle 10 -> REQ next cycle with `cpu_save` never asserted. `cpu_yield` alone -> SAVE next cycle, `slice_cnt`=54.
- **Yield disabled**: macro undefined, `cpu_yield` pulsed at cycle 10 -> the slice still runs 64 cycles.
- **Async reset in SAVE**: assert `rst`=0 while `cpu_save`=1 -> `cpu_save`=0 before the next clock edge, `switch_cnt`=0, and the sequence restarts after release.

Source files
------------

// File: rtl/thread_slice_ctl.sv
// thread_slice_ctl: time-slice controller between the threads manager and the
// CPU core. Requests the next runnable thread, latches its start address and
// state pointer, loads them into the core, runs a fixed quantum and then has
// the core save its context before requesting again.
//
// Optional feature macro: THRD_SLICE_YIELD_EN
//   defined   - cpu_yield in RUN ends the slice early (below stop_hit).
//   undefined - cpu_yield is ignored; slices end on expiry or stop_hit.

module thread_slice_ctl #(
    parameter int          QUANTUM                   = 64,
    parameter int          CNT_W                     = 8,
    parameter int          WAIT_MAX                  = 15,
    parameter int          DATA_SIZE                 = 32,
    parameter logic [3:0]  THREAD_CMD_GET_NEXT_STATE = 4'h4
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [3:0]           thrd_cmd,
    input  logic                 sel_vld,
    input  logic [DATA_SIZE-1:0] next_proc,
    input  logic [DATA_SIZE-1:0] proc_state,
    output logic                 cpu_load,
    output logic [DATA_SIZE-1:0] cpu_pc,
    output logic [DATA_SIZE-1:0] cpu_state_ptr,
    output logic                 cpu_save,
    input  logic                 cpu_save_done,
    input  logic                 cpu_yield,
    input  logic                 stop_hit,
    output logic                 running,
    output logic [CNT_W-1:0]     slice_cnt,
    output logic [15:0]          switch_cnt
);

    // Wait counter only has to reach WAIT_MAX (expected to be at least 1).
    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0]  QUANT_VAL = CNT_W'(QUANTUM);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        LOAD = 3'd3,
        RUN  = 3'd4,
        SAVE = 3'd5
    } state_t;

    state_t                state_q,    state_d;
    logic [WAIT_W-1:0]     wait_q,     wait_d;
    logic [WAIT_W-1:0]     waitNext;
    logic [3:0]            thrd_cmd_q, thrd_cmd_d;
    logic                  cpu_load_q, cpu_load_d;
    logic                  cpu_save_q, cpu_save_d;
    logic                  running_q,  running_d;
    logic [DATA_SIZE-1:0]  cpu_pc_q,   cpu_pc_d;
    logic [DATA_SIZE-1:0]  cpu_sp_q,   cpu_sp_d;
    logic [CNT_W-1:0]      slice_q,    slice_d;
    logic [15:0]           switch_q,   switch_d;

`ifndef THRD_SLICE_YIELD_EN
    // Yield has no effect in this build; keep the input visibly consumed.
    logic unusedYield;
    assign unusedYield = cpu_yield;
`endif

    assign waitNext = wait_q + 1'b1;

    // Next-state and next-output logic; every output register is a function
    // of the state being entered so the pulses line up with their state.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        cpu_pc_d = cpu_pc_q;
        cpu_sp_d = cpu_sp_q;
        slice_d  = slice_q;
        switch_d = switch_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (sel_vld) begin
                    if (next_proc != '0) begin
                        cpu_pc_d = next_proc;
                        cpu_sp_d = proc_state;
                        state_d  = LOAD;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    wait_d = waitNext;
                    if (waitNext == WAIT_LIM) begin
                        state_d = REQ;
                    end
                end
            end
            LOAD: begin
                slice_d  = QUANT_VAL;
                switch_d = switch_q + 16'd1;
                state_d  = RUN;
            end
            RUN: begin
                slice_d = slice_q - LAST_CNT;
                if (stop_hit) begin
                    state_d = REQ;
                end
`ifdef THRD_SLICE_YIELD_EN
                else if (cpu_yield) begin
                    state_d = SAVE;
                end
`endif
                else if (slice_q == LAST_CNT) begin
                    state_d = SAVE;
                end
            end
            SAVE: begin
                if (cpu_save_done) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        thrd_cmd_d = (state_d == REQ) ? THREAD_CMD_GET_NEXT_STATE : 4'h0;
        cpu_load_d = (state_d == LOAD);
        running_d  = (state_d == RUN);
        cpu_save_d = (state_d == SAVE);
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            thrd_cmd_q <= 4'h0;
            cpu_load_q <= 1'b0;
            cpu_save_q <= 1'b0;
            running_q  <= 1'b0;
            cpu_pc_q   <= '0;
            cpu_sp_q   <= '0;
            slice_q    <= '0;
            switch_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            thrd_cmd_q <= thrd_cmd_d;
            cpu_load_q <= cpu_load_d;
            cpu_save_q <= cpu_save_d;
            running_q  <= running_d;
            cpu_pc_q   <= cpu_pc_d;
            cpu_sp_q   <= cpu_sp_d;
            slice_q    <= slice_d;
            switch_q   <= switch_d;
        end
    end

    assign thrd_cmd      = thrd_cmd_q;
    assign cpu_load      = cpu_load_q;
    assign cpu_save      = cpu_save_q;
    assign running       = running_q;
    assign cpu_pc        = cpu_pc_q;
    assign cpu_state_ptr = cpu_sp_q;
    assign slice_cnt     = slice_q;
    assign switch_cnt    = switch_q;

endmodule

// File: tb/tb_thread_slice_ctl.sv
// Testbench for thread_slice_ctl. The driver plays both the threads manager
// and the CPU core, deciding every response up front and predicting from the
// slice timing rules the cycle and content of each visible event (request
// pulse, load pulse, start of save). A negedge monitor pops those predictions
// as events appear on the outputs.

module tb_thread_slice_ctl;

    localparam int         Q   = 64;
    localparam int         CW  = 8;
    localparam int         WM  = 15;
    localparam int         DW  = 32;
    localparam logic [3:0] CMD = 4'h4;

    localparam int K_REQ  = 0;
    localparam int K_LOAD = 1;
    localparam int K_SAVE = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] pc;
        logic [31:0] sp;
        int          slice;
        int          sw;
        int          runs;
    } expT;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [3:0]     thrd_cmd;
    logic           sel_vld = 1'b0;
    logic [DW-1:0]  next_proc = '0;
    logic [DW-1:0]  proc_state = '0;
    logic           cpu_load;
    logic [DW-1:0]  cpu_pc;
    logic [DW-1:0]  cpu_state_ptr;
    logic           cpu_save;
    logic           cpu_save_done = 1'b0;
    logic           cpu_yield = 1'b0;
    logic           stop_hit = 1'b0;
    logic           running;
    logic [CW-1:0]  slice_cnt;
    logic [15:0]    switch_cnt;

    expT         expQ[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          r = 0;
    logic [15:0] expSwitch = 16'd0;
    int          runCount = 0;
    logic        prevSave = 1'b0;

    thread_slice_ctl #(
        .QUANTUM                   (Q),
        .CNT_W                     (CW),
        .WAIT_MAX                  (WM),
        .DATA_SIZE                 (DW),
        .THREAD_CMD_GET_NEXT_STATE (CMD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .thrd_cmd      (thrd_cmd),
        .sel_vld       (sel_vld),
        .next_proc     (next_proc),
        .proc_state    (proc_state),
        .cpu_load      (cpu_load),
        .cpu_pc        (cpu_pc),
        .cpu_state_ptr (cpu_state_ptr),
        .cpu_save      (cpu_save),
        .cpu_save_done (cpu_save_done),
        .cpu_yield     (cpu_yield),
        .stop_hit      (stop_hit),
        .running       (running),
        .slice_cnt     (slice_cnt),
        .switch_cnt    (switch_cnt)
    );

    // Free-running clock and cycle index used for event timing.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case the run wanders off.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic pushExp(input int kind, input int c, input logic [31:0] pc, input logic [31:0] sp,
                           input int slice, input int sw, input int runs);
        expT e;
        e.kind  = kind;
        e.cyc   = c;
        e.pc    = pc;
        e.sp    = sp;
        e.slice = slice;
        e.sw    = sw;
        e.runs  = runs;
        expQ.push_back(e);
    endtask

    // Compare one observed output event against the oldest prediction.
    task automatic checkOutput(input int kind);
        expT e;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected-event: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = expQ.pop_front();
            checkVal("event-kind", kind, e.kind);
            checkVal("event-cycle", cyc, e.cyc);
            if (kind == e.kind) begin
                case (kind)
                    K_REQ: checkVal("req-cmd", {28'd0, thrd_cmd}, {28'd0, CMD});
                    K_LOAD: begin
                        checkVal("load-pc", cpu_pc, e.pc);
                        checkVal("load-sp", cpu_state_ptr, e.sp);
                    end
                    default: begin
                        checkVal("save-slice", {24'd0, slice_cnt}, e.slice);
                        checkVal("save-switch", {16'd0, switch_cnt}, e.sw);
                        checkVal("save-pc", cpu_pc, e.pc);
                        checkVal("save-runcycles", runCount, e.runs);
                    end
                endcase
            end
        end
    endtask

    // Monitor: detect output events away from the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            prevSave = 1'b0;
            runCount = 0;
        end else begin
            if (running) runCount++;
            if (thrd_cmd != 4'h0) checkOutput(K_REQ);
            if (cpu_load) begin
                checkOutput(K_LOAD);
                runCount = 0;
            end
            if (cpu_save && !prevSave) checkOutput(K_SAVE);
            prevSave = cpu_save;
        end
    end

    // Advance to just after the rising edge that starts cycle c.
    task automatic goToCycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "-thrd_cmd"}, {28'd0, thrd_cmd}, 32'd0);
        checkVal({tag, "-cpu_load"}, {31'd0, cpu_load}, 32'd0);
        checkVal({tag, "-cpu_save"}, {31'd0, cpu_save}, 32'd0);
        checkVal({tag, "-cpu_pc"}, cpu_pc, 32'd0);
        checkVal({tag, "-cpu_state_ptr"}, cpu_state_ptr, 32'd0);
        checkVal({tag, "-running"}, {31'd0, running}, 32'd0);
        checkVal({tag, "-slice_cnt"}, {24'd0, slice_cnt}, 32'd0);
        checkVal({tag, "-switch_cnt"}, {16'd0, switch_cnt}, 32'd0);
    endtask

    // One manager/core exchange starting from the request in cycle r.
    // d: WAIT cycles before sel_vld (>= WM means never answer).
    // mode: 0 expiry, 1 stop, 2 yield, 3 stop+yield at slice cycle j (1-based).
    // e: SAVE cycles before cpu_save_done (< 0 leaves the save pending).
    task automatic runSlice(input int d, input logic [31:0] np, input logic [31:0] sp,
                            input int mode, input int j, input int e, output int sEnd);
        int w;
        int ev;
        int s;
        int slc;
        int runs;
        bit yieldWins;
        sEnd = -1;
        if (d >= WM) begin
            r = r + 1 + WM;
            pushExp(K_REQ, r, 0, 0, 0, 0, 0);
            return;
        end
        w = r + 1 + d;
        goToCycle(w);
        sel_vld    = 1'b1;
        next_proc  = np;
        proc_state = sp;
        if (np == 32'd0) begin
            r = w + 2;
            pushExp(K_REQ, r, 0, 0, 0, 0, 0);
            goToCycle(w + 1);
            sel_vld   = 1'b0;
            next_proc = $urandom;
            return;
        end
        expSwitch = expSwitch + 16'd1;
        pushExp(K_LOAD, w + 1, np, sp, 0, 0, 0);
        goToCycle(w + 1);
        sel_vld    = 1'b0;
        next_proc  = $urandom;
        proc_state = $urandom;
        // A selection offered while running must not be latched.
        goToCycle(w + 2);
        sel_vld   = 1'b1;
        next_proc = np | 32'h8000_0000;
        goToCycle(w + 3);
        sel_vld   = 1'b0;

`ifdef THRD_SLICE_YIELD_EN
        yieldWins = 1'b1;
`else
        yieldWins = 1'b0;
`endif
        ev = w + 1 + j;
        if (mode == 1 || mode == 3) begin
            r = ev + 1;
            pushExp(K_REQ, r, 0, 0, 0, 0, 0);
            goToCycle(ev);
            stop_hit  = 1'b1;
            cpu_yield = (mode == 3);
            goToCycle(ev + 1);
            stop_hit  = 1'b0;
            cpu_yield = 1'b0;
            return;
        end
        if (mode == 2 && yieldWins) begin
            s    = ev + 1;
            slc  = Q - j;
            runs = j;
        end else begin
            s    = w + 2 + Q;
            slc  = 0;
            runs = Q;
        end
        pushExp(K_SAVE, s, np, sp, slc, int'(expSwitch), runs);
        if (mode == 2) begin
            goToCycle(ev);
            cpu_yield = 1'b1;
            goToCycle(ev + 1);
            cpu_yield = 1'b0;
        end
        goToCycle(s);
        stop_hit = 1'b1;
        if (e < 0) begin
            sEnd = s;
            return;
        end
        r = s + e + 1;
        pushExp(K_REQ, r, 0, 0, 0, 0, 0);
        goToCycle(s + e);
        cpu_save_done = 1'b1;
        goToCycle(s + e + 1);
        cpu_save_done = 1'b0;
        stop_hit      = 1'b0;
    endtask

    task automatic applyStimulus();
        int sEnd;
        int d;
        int mode;
        int j;
        int e;
        logic [31:0] np;
        logic [31:0] sp;

        // Outputs while held in reset.
        repeat (3) @(negedge clk);
        checkAllZero("reset");

        // Release: first request appears in the following cycle.
        rst = 1'b1;
        r = cyc + 1;
        pushExp(K_REQ, r, 0, 0, 0, 0, 0);

        // Directed: full slice, empty selection, timeout, stop vs yield.
        runSlice(0, 32'h100, 32'h2000, 0, 0, 3, sEnd);
        runSlice(0, 32'h0, 32'h0, 0, 0, 0, sEnd);
        runSlice(WM, 32'h0, 32'h0, 0, 0, 0, sEnd);
        runSlice(2, 32'h0000_1234, 32'h0000_5678, 3, 10, 1, sEnd);
        runSlice(1, 32'h0000_4321, 32'h0000_8765, 2, 10, 0, sEnd);

        // Randomized exchanges.
        for (int i = 0; i < 40; i++) begin
            d    = int'($urandom_range(0, WM + 2));
            np   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(1, 32'h7FFF_FFFF);
            sp   = $urandom;
            mode = int'($urandom_range(0, 3));
            j    = int'($urandom_range(2, Q));
            e    = int'($urandom_range(0, 3));
            runSlice(d, np, sp, mode, j, e, sEnd);
        end

        // Asynchronous reset while a save is pending.
        runSlice(0, 32'h0000_0ABC, 32'h0000_0DEF, 0, 0, -1, sEnd);
        goToCycle(sEnd + 1);
        checkVal("pre-reset-cpu_save", {31'd0, cpu_save}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("async-reset");
        stop_hit = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expSwitch = 16'd0;
        rst = 1'b1;
        r = cyc + 1;
        pushExp(K_REQ, r, 0, 0, 0, 0, 0);
        runSlice(0, 32'h0000_0777, 32'h0000_0888, 0, 0, 0, sEnd);

        goToCycle(r + 3);
        checkVal("leftover-expectations", expQ.size(), 32'd0);
    endtask

    initial begin
        applyStimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
